// File: rtl/sum_4b_pkg.sv
// Shared constants for the registered 4-bit adder: operand width and the
// values every output register takes while reset is asserted.
package sum_4b_pkg;

    // Operand/result width; the datapath is built for exactly this value.
    localparam int SUM_4B_WIDTH = 4;

    // Reset values of the output registers.
    localparam logic [SUM_4B_WIDTH-1:0] SUM_RST   = '0;
    localparam logic                    COUT_RST  = 1'b0;
    localparam logic                    OVF_RST   = 1'b0;
    localparam logic                    VALID_RST = 1'b0;

endpackage : sum_4b_pkg

// File: rtl/sum_4b_full_adder.sv
// One-bit full adder cell, the building block of the ripple chain in sum_4b.
// Purely combinational: no clock, no state.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the parity of the three inputs; carry is generated by a&b or
    // propagated from ci when exactly one of a/b is set.
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder

// File: rtl/sum_4b.sv
// Registered 4-bit adder: {Cout,Sum} = A + B + Cin, one cycle latency,
// one operand set accepted per cycle.
// Optional feature: define SUM_4B_OVF_EN to add the signed-overflow output
// Ovf and its register; without it the port and its logic do not exist.
module sum_4b
    import sum_4b_pkg::*;
#(
    parameter int WIDTH = SUM_4B_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
`ifdef SUM_4B_OVF_EN
    output logic             Ovf,
`endif
    output logic             Cout
);

    // carry[0] is the external carry-in; carry[WIDTH] leaves as Cout.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sumComb;

    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             valid_q, valid_d;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sumComb[i]),
            .co (carry[i+1])
        );
    end

    // Next-state: capture a new result only when operands are valid,
    // otherwise hold the previous result; out_valid follows in_valid.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = sumComb;
            cout_d = carry[WIDTH];
        end
    end

    // Output registers with synchronous reset; reset wins over in_valid so
    // operands presented during reset are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= SUM_RST;
            cout_q  <= COUT_RST;
            valid_q <= VALID_RST;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

`ifdef SUM_4B_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: both addends share a sign that the result lacks.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sumComb[WIDTH-1] != A[WIDTH-1]);
        end
    end

    // Overflow register, reset and enabled exactly like Sum/Cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= OVF_RST;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

endmodule : sum_4b

// File: tb/tb_sum_4b.sv
// Testbench for sum_4b: directed table, exhaustive back-to-back sweep and a
// randomized run checked against an arithmetic reference model.
// Build with SUM_4B_OVF_EN defined to also exercise the Ovf output.
module tb_sum_4b;

    // Expected output bundle.
    typedef struct packed {
        logic       valid;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    // One directed vector: inputs plus expected registered outputs.
    typedef struct {
        string      name;
        logic       rst;
        logic       inValid;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        exp_t       e;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       out_valid;
    logic [3:0] Sum;
    logic       Cout;
`ifdef SUM_4B_OVF_EN
    logic       Ovf;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: last accepted result, held across idle cycles.
    int   modelTotal = 0;
    logic modelOvf   = 1'b0;

    sum_4b #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .Sum       (Sum),
`ifdef SUM_4B_OVF_EN
        .Ovf       (Ovf),
`endif
        .Cout      (Cout)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it in, then settle past the edge.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic c);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = c;
        @(posedge clk);
        #1;
    endtask

    // Compare registered outputs against the expected bundle.
    task automatic checkOutput(input string name, input exp_t e);
        compared++;
        if (out_valid !== e.valid) begin
            mismatched++;
            $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, e.valid);
        end
        compared++;
        if (Sum !== e.sum) begin
            mismatched++;
            $display("[TB] FAIL %s Sum: got %0d expected %0d", name, Sum, e.sum);
        end
        compared++;
        if (Cout !== e.cout) begin
            mismatched++;
            $display("[TB] FAIL %s Cout: got %b expected %b", name, Cout, e.cout);
        end
`ifdef SUM_4B_OVF_EN
        compared++;
        if (Ovf !== e.ovf) begin
            mismatched++;
            $display("[TB] FAIL %s Ovf: got %b expected %b", name, Ovf, e.ovf);
        end
`endif
    endtask

    // Advance the reference model by one cycle and return its outputs.
    // Ovf is derived from the signed range of the exact sum.
    function automatic exp_t modelStep(input logic r, input logic v,
                                       input logic [3:0] a, input logic [3:0] b,
                                       input logic c);
        exp_t e;
        int   sa, sb, st;
        if (r) begin
            modelTotal = 0;
            modelOvf   = 1'b0;
            e.valid    = 1'b0;
        end else if (v) begin
            modelTotal = int'(a) + int'(b) + int'(c);
            sa = (a >= 8) ? int'(a) - 16 : int'(a);
            sb = (b >= 8) ? int'(b) - 16 : int'(b);
            st = sa + sb + int'(c);
            modelOvf   = (st > 7) || (st < -8);
            e.valid    = 1'b1;
        end else begin
            e.valid    = 1'b0;
        end
        e.sum  = 4'(modelTotal % 16);
        e.cout = (modelTotal >= 16);
        e.ovf  = modelOvf;
        return e;
    endfunction

    vec_t vecs[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;

        // Directed vectors: name, rst, in_valid, A, B, Cin, {valid,sum,cout,ovf}.
        vecs.push_back('{"reset0",    1'b1, 1'b1, 4'd9,  4'd9,  1'b0, '{1'b0, 4'd0,  1'b0, 1'b0}});
        vecs.push_back('{"reset1",    1'b1, 1'b1, 4'd9,  4'd9,  1'b0, '{1'b0, 4'd0,  1'b0, 1'b0}});
        vecs.push_back('{"basic",     1'b0, 1'b1, 4'd1,  4'd2,  1'b0, '{1'b1, 4'd3,  1'b0, 1'b0}});
        vecs.push_back('{"wrap15_1",  1'b0, 1'b1, 4'd15, 4'd1,  1'b0, '{1'b1, 4'd0,  1'b1, 1'b0}});
        vecs.push_back('{"wrap15_15", 1'b0, 1'b1, 4'd15, 4'd15, 1'b1, '{1'b1, 4'd15, 1'b1, 1'b0}});
        vecs.push_back('{"hold_set",  1'b0, 1'b1, 4'd3,  4'd4,  1'b0, '{1'b1, 4'd7,  1'b0, 1'b0}});
        vecs.push_back('{"hold_idle", 1'b0, 1'b0, 4'd8,  4'd8,  1'b0, '{1'b0, 4'd7,  1'b0, 1'b0}});
        vecs.push_back('{"ovf7_1",    1'b0, 1'b1, 4'd7,  4'd1,  1'b0, '{1'b1, 4'd8,  1'b0, 1'b1}});
        vecs.push_back('{"ovf8_8",    1'b0, 1'b1, 4'd8,  4'd8,  1'b0, '{1'b1, 4'd0,  1'b1, 1'b1}});
        vecs.push_back('{"noovf3_2",  1'b0, 1'b1, 4'd3,  4'd2,  1'b0, '{1'b1, 4'd5,  1'b0, 1'b0}});
        vecs.push_back('{"rst_drop",  1'b1, 1'b1, 4'd5,  4'd5,  1'b0, '{1'b0, 4'd0,  1'b0, 1'b0}});
        vecs.push_back('{"post_rst",  1'b0, 1'b0, 4'd6,  4'd6,  1'b1, '{1'b0, 4'd0,  1'b0, 1'b0}});
        vecs.push_back('{"first_res", 1'b0, 1'b1, 4'd6,  4'd6,  1'b1, '{1'b1, 4'd13, 1'b0, 1'b1}});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].inValid, vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOutput(vecs[i].name, vecs[i].e);
        end

        // Back-to-back throughput corner: two results on consecutive cycles
        // and then an idle cycle that must hold the second one.
        applyStimulus(1'b0, 1'b1, 4'd2, 4'd2, 1'b0);
        checkOutput("b2b_first", '{1'b1, 4'd4, 1'b0, 1'b0});
        applyStimulus(1'b0, 1'b1, 4'd9, 4'd9, 1'b1);
        checkOutput("b2b_second", '{1'b1, 4'd3, 1'b1, 1'b1});
        applyStimulus(1'b0, 1'b0, 4'd1, 4'd1, 1'b1);
        checkOutput("b2b_hold", '{1'b0, 4'd3, 1'b1, 1'b1});

        // Exhaustive sweep of every A/B/Cin combination, one per cycle.
        void'(modelStep(1'b1, 1'b0, 4'd0, 4'd0, 1'b0));
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        for (int n = 0; n < 512; n++) begin
            logic [3:0] a, b;
            logic       c;
            exp_t       e;
            a = 4'(n >> 5);
            b = 4'(n >> 1);
            c = n[0];
            e = modelStep(1'b0, 1'b1, a, b, c);
            applyStimulus(1'b0, 1'b1, a, b, c);
            checkOutput("sweep", e);
        end

        // Randomized run with sporadic reset and idle cycles.
        for (int n = 0; n < 400; n++) begin
            logic       r, v, c;
            logic [3:0] a, b;
            exp_t       e;
            r = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 1'($urandom_range(0, 1));
            e = modelStep(r, v, a, b, c);
            applyStimulus(r, v, a, b, c);
            checkOutput("random", e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_sum_4b
